// File: rtl/sad_best_match_if.sv
// Row-input and best-match-output bundle between the SAD compute stage,
// the best-match selector and the MV writeback.
interface sad_best_match_if #(
    parameter int ACC_W = 15
);
    logic [59:0]      sad_in;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       best_idx;
    logic [ACC_W-1:0] best_sad;
    logic [2:0]       mv_frac;

    modport slave (
        input  sad_in, in_valid, out_ready,
        output in_ready, out_valid, best_idx, best_sad, mv_frac
    );

    modport master (
        output sad_in, in_valid, out_ready,
        input  in_ready, out_valid, best_idx, best_sad, mv_frac
    );
endinterface

// File: rtl/sad_best_match.sv
// Accumulates five per-row sub-pel SADs over ROWS rows, then picks the
// cheapest candidate with one comparison per cycle and offers it downstream.
module sad_best_match #(
    parameter int ROWS  = 8,
    parameter int ACC_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    sad_best_match_if.slave  bus
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    typedef enum logic [1:0] {ACCUM, COMPARE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4:0][ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]          row_cnt_q, row_cnt_d;
    logic [2:0]             step_q, step_d;
    logic [2:0]             best_idx_q, best_idx_d;
    logic [ACC_W-1:0]       best_sad_q, best_sad_d;
    logic [2:0]             cand_idx;
    logic                   in_ready, out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            row_cnt_q  <= '0;
            step_q     <= '0;
            best_idx_q <= 3'd2;
            best_sad_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            row_cnt_q  <= row_cnt_d;
            step_q     <= step_d;
            best_idx_q <= best_idx_d;
            best_sad_q <= best_sad_d;
        end
    end

    // Step 0 seeds best with the full-pel sum; steps 1..4 sweep in tie-break order.
    always_comb begin
        cand_idx = 3'd2;
        case (step_q)
            3'd1:    cand_idx = 3'd1;
            3'd2:    cand_idx = 3'd3;
            3'd3:    cand_idx = 3'd0;
            3'd4:    cand_idx = 3'd4;
            default: cand_idx = 3'd2;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        row_cnt_d  = row_cnt_q;
        step_d     = step_q;
        best_idx_d = best_idx_q;
        best_sad_d = best_sad_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    for (int i = 0; i < 5; i++)
                        acc_d[i] = acc_q[i] + ACC_W'(bus.sad_in[12*i +: 12]);
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = COMPARE;
                        step_d  = '0;
                    end
                end
            end
            COMPARE: begin
                if (step_q == 3'd0) begin
                    best_sad_d = acc_q[2];
                    best_idx_d = 3'd2;
                end else if (acc_q[cand_idx] < best_sad_q) begin
                    best_sad_d = acc_q[cand_idx];
                    best_idx_d = cand_idx;
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd4)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_d     = '0;
                    row_cnt_d = '0;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.best_idx  = best_idx_q;
    assign bus.best_sad  = best_sad_q;

    always_comb begin
        case (best_idx_q)
            3'd0:    bus.mv_frac = 3'b001;
            3'd1:    bus.mv_frac = 3'b010;
            3'd3:    bus.mv_frac = 3'b110;
            3'd4:    bus.mv_frac = 3'b111;
            default: bus.mv_frac = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_sad_best_match.sv
// Randomized and directed checks of sad_best_match against a sum/argmin model.
module tb_sad_best_match;
    localparam int ROWS  = 8;
    localparam int ACC_W = 15;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   exp_sum[5];

    always #5 clk = ~clk;

    sad_best_match_if #(.ACC_W(ACC_W)) bus ();

    sad_best_match #(.ROWS(ROWS), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] pack(input int q0, input int h1, input int f,
                                         input int h3, input int q4);
        logic [59:0] r;
        r[11:0]  = 12'(q0);
        r[23:12] = 12'(h1);
        r[35:24] = 12'(f);
        r[47:36] = 12'(h3);
        r[59:48] = 12'(q4);
        return r;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 5; i++) exp_sum[i] = 0;
    endfunction

    // Lowest sum wins; among equal sums the preference is full, rh, lh, rq, lq.
    function automatic int ref_idx();
        int ord[5];
        int m;
        ord = '{2, 1, 3, 0, 4};
        m = exp_sum[0];
        for (int i = 1; i < 5; i++) if (exp_sum[i] < m) m = exp_sum[i];
        for (int i = 0; i < 5; i++) if (exp_sum[ord[i]] == m) return ord[i];
        return 2;
    endfunction

    function automatic int ref_frac(input int idx);
        case (idx)
            0: return 1;
            1: return 2;
            3: return -2;
            4: return -1;
            default: return 0;
        endcase
    endfunction

    task automatic send_row(input logic [59:0] row);
        bus.in_valid = 1'b1;
        bus.sad_in   = row;
        for (int i = 0; i < 5; i++) exp_sum[i] += int'(row[12*i +: 12]);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b0;
            bus.sad_in   = {$urandom, $urandom};
            tick();
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_model();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.best_idx !== 3'd2 ||
            bus.best_sad !== '0 || bus.mv_frac !== 3'b000) begin
            failures++;
            $display("FAIL reset_initial: rdy=%b vld=%b idx=%0d sad=%0d frac=%b want 1 0 2 0 000",
                     bus.in_ready, bus.out_valid, bus.best_idx, bus.best_sad, bus.mv_frac);
        end
        for (int r = 0; r < 3; r++) send_row({$urandom, $urandom});
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_model();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.best_idx !== 3'd2 ||
            bus.best_sad !== '0 || bus.mv_frac !== 3'b000) begin
            failures++;
            $display("FAIL reset_midblock: rdy=%b vld=%b idx=%0d sad=%0d frac=%b want 1 0 2 0 000",
                     bus.in_ready, bus.out_valid, bus.best_idx, bus.best_sad, bus.mv_frac);
        end
        for (int r = 0; r < ROWS; r++) send_row(pack(10, 10, 10, 10, 10));
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd2 || bus.best_sad !== 15'd80) begin
            failures++;
            $display("FAIL reset_followup: vld=%b idx=%0d sad=%0d want 1 2 80",
                     bus.out_valid, bus.best_idx, bus.best_sad);
        end
        accept();
    endtask

    task automatic test_latency_order();
        int cyc;
        for (int r = 0; r < ROWS; r++) send_row(pack(60, 70, 80, 90, 100));
        wait_done(cyc);
        checks++;
        if (cyc != 5 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency: cycles=%0d vld=%b want 5 1", cyc, bus.out_valid);
        end
        checks++;
        if (bus.best_idx !== 3'd0 || bus.best_sad !== 15'd480 || bus.mv_frac !== 3'b001) begin
            failures++;
            $display("FAIL order_result: idx=%0d sad=%0d frac=%b want 0 480 001",
                     bus.best_idx, bus.best_sad, bus.mv_frac);
        end
        accept();
    endtask

    task automatic test_ties();
        int cyc;
        for (int r = 0; r < ROWS; r++) send_row(pack(50, 50, 50, 50, 50));
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd2 || bus.best_sad !== 15'd400) begin
            failures++;
            $display("FAIL tie_all: vld=%b idx=%0d sad=%0d want 1 2 400",
                     bus.out_valid, bus.best_idx, bus.best_sad);
        end
        accept();
        for (int r = 0; r < ROWS; r++) send_row(pack(40, 40, 100, 40, 40));
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd1 || bus.best_sad !== 15'd320 ||
            bus.mv_frac !== 3'b010) begin
            failures++;
            $display("FAIL tie_half: vld=%b idx=%0d sad=%0d frac=%b want 1 1 320 010",
                     bus.out_valid, bus.best_idx, bus.best_sad, bus.mv_frac);
        end
        accept();
    endtask

    task automatic test_backpressure();
        int cyc;
        int eidx;
        for (int r = 0; r < ROWS; r++)
            send_row(pack($urandom_range(0, 1530), $urandom_range(0, 1530),
                          $urandom_range(0, 1530), $urandom_range(0, 1530),
                          $urandom_range(0, 1530)));
        wait_done(cyc);
        eidx = ref_idx();
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            bus.sad_in   = {$urandom, $urandom};
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.best_idx !== 3'(eidx) || bus.best_sad !== ACC_W'(exp_sum[eidx])) begin
                failures++;
                $display("FAIL backpressure_hold c=%0d: vld=%b rdy=%b idx=%0d sad=%0d want 1 0 %0d %0d",
                         c, bus.out_valid, bus.in_ready, bus.best_idx, bus.best_sad,
                         eidx, exp_sum[eidx]);
            end
        end
        bus.in_valid = 1'b1;
        bus.sad_in   = pack(1000, 1000, 1000, 1000, 1000);
        accept();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        for (int r = 0; r < ROWS; r++) send_row(pack(3, 2, 7, 9, 4));
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd1 || bus.best_sad !== 15'd16) begin
            failures++;
            $display("FAIL backpressure_next_block: vld=%b idx=%0d sad=%0d want 1 1 16",
                     bus.out_valid, bus.best_idx, bus.best_sad);
        end
        accept();
    endtask

    task automatic test_sparse();
        int cyc;
        for (int r = 0; r < ROWS; r++) begin
            idle($urandom_range(0, 3));
            send_row(pack(200, 200, 200, 200, 5));
        end
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd4 || bus.best_sad !== 15'd40 ||
            bus.mv_frac !== 3'b111) begin
            failures++;
            $display("FAIL sparse: vld=%b idx=%0d sad=%0d frac=%b want 1 4 40 111",
                     bus.out_valid, bus.best_idx, bus.best_sad, bus.mv_frac);
        end
        accept();
    endtask

    task automatic test_max();
        int cyc;
        for (int r = 0; r < ROWS; r++) send_row(pack(1530, 1530, 1530, 1530, 1530));
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd2 || bus.best_sad !== 15'd12240) begin
            failures++;
            $display("FAIL max_values: vld=%b idx=%0d sad=%0d want 1 2 12240",
                     bus.out_valid, bus.best_idx, bus.best_sad);
        end
        accept();
        for (int r = 0; r < ROWS; r++) send_row(pack(4095, 4095, 4095, 4095, 4094));
        wait_done(cyc);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.best_idx !== 3'd4 || bus.best_sad !== 15'd32752) begin
            failures++;
            $display("FAIL oversize_nowrap: vld=%b idx=%0d sad=%0d want 1 4 32752",
                     bus.out_valid, bus.best_idx, bus.best_sad);
        end
        accept();
    endtask

    task automatic test_random();
        int cyc;
        int eidx;
        int cv[5];
        logic tie_mode;
        for (int b = 0; b < 20; b++) begin
            tie_mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < 5; i++) cv[i] = 10 * $urandom_range(1, 2);
            for (int r = 0; r < ROWS; r++) begin
                idle($urandom_range(0, 2));
                if (tie_mode) send_row(pack(cv[0], cv[1], cv[2], cv[3], cv[4]));
                else send_row(pack($urandom_range(0, 1530), $urandom_range(0, 1530),
                                   $urandom_range(0, 1530), $urandom_range(0, 1530),
                                   $urandom_range(0, 1530)));
            end
            wait_done(cyc);
            eidx = ref_idx();
            checks++;
            if (bus.out_valid !== 1'b1 || cyc != 5 || bus.best_idx !== 3'(eidx) ||
                bus.best_sad !== ACC_W'(exp_sum[eidx]) ||
                int'($signed(bus.mv_frac)) != ref_frac(eidx)) begin
                failures++;
                $display("FAIL random_block %0d: vld=%b cyc=%0d idx=%0d sad=%0d frac=%b want 1 5 %0d %0d %0d",
                         b, bus.out_valid, cyc, bus.best_idx, bus.best_sad, bus.mv_frac,
                         eidx, exp_sum[eidx], ref_frac(eidx));
            end
            idle($urandom_range(0, 3));
            accept();
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.sad_in    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_model();
        test_reset();
        test_latency_order();
        test_ties();
        test_backpressure();
        test_sparse();
        test_max();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
